// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl_pkg
// Desc     : Shared types and constants for the instruction fetch controller:
//            fetch FSM state encoding, default widths/reset address and the
//            fixed instruction size.
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_ctrl_pkg;

   // REQ: request may be issued, WAIT: one request outstanding,
   // DRAIN: one stale response still to arrive and be dropped
   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   localparam int          XLEN_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          INSTR_BYTES      = 4;

   // Instructions are word aligned; a branch target with nonzero low bits is illegal
   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_branch_stats.sv
`default_nettype none
// ============================================================================
// Module   : branch_stats
// Desc     : Saturating 32-bit counters of resolved branches and of taken,
//            aligned redirects. Only built when PC_FETCH_BRANCH_STATS_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module branch_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_valid_i,
   input  logic        redirect_i,
   output logic [31:0] br_cnt_o,
   output logic [31:0] taken_cnt_o
);

   // Count events, holding at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_cnt_o    <= 32'h0;
         taken_cnt_o <= 32'h0;
      end else begin
         if (br_valid_i && (br_cnt_o != 32'hFFFF_FFFF)) begin
            br_cnt_o <= br_cnt_o + 32'd1;
         end
         if (redirect_i && (taken_cnt_o != 32'hFFFF_FFFF)) begin
            taken_cnt_o <= taken_cnt_o + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Desc     : Instruction fetch controller. Owns the PC, issues one request at
//            a time to instruction memory, hands fetched words to decode and
//            applies branch redirects with a one-cycle flush pulse.
// Config   : define PC_FETCH_BRANCH_STATS_EN to add br_cnt_o / taken_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            br_valid_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic            flush_o,
   output logic            misalign_o
`ifdef PC_FETCH_BRANCH_STATS_EN
   ,
   output logic [31:0]     br_cnt_o,
   output logic [31:0]     taken_cnt_o
`endif
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] pc;

   logic take;
   logic redirect;
   logic misalign_evt;
   logic hold;
   logic req_fire;
   logic resp_fire;

   assign take         = br_valid_i & br_taken_i;
   assign redirect     = take & is_aligned(br_target_i[1:0]);
   assign misalign_evt = take & ~is_aligned(br_target_i[1:0]);
   // Decode is holding a valid word: fetching more would have nowhere to go
   assign hold         = if_valid_o & stall_i;

   assign imem_req_o   = rst_n & (state == ST_REQ) & ~hold;
   assign imem_addr_o  = pc;
   assign req_fire     = imem_req_o & imem_gnt_i;
   assign resp_fire    = (state == ST_WAIT) & imem_rvalid_i;

   // Fetch FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_REQ;
      end else begin
         state <= state_next;
      end
   end

   // Next state: a redirect with a request in flight must drop its response
   always_comb begin
      state_next = state;
      case (state)
         ST_REQ: begin
            if (req_fire) begin
               state_next = redirect ? ST_DRAIN : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid_i) begin
               state_next = ST_REQ;
            end else if (redirect) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (imem_rvalid_i) begin
               state_next = ST_REQ;
            end
         end
         default: state_next = ST_REQ;
      endcase
   end

   // PC, decode-side outputs and the one-cycle flush/misalign pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         if_valid_o <= 1'b0;
         if_instr_o <= '0;
         if_pc_o    <= '0;
         flush_o    <= 1'b0;
         misalign_o <= 1'b0;
      end else begin
         flush_o    <= redirect;
         misalign_o <= misalign_evt;
         if (redirect) begin
            pc         <= br_target_i;
            if_valid_o <= 1'b0;
         end else if (resp_fire) begin
            if_valid_o <= 1'b1;
            if_instr_o <= imem_rdata_i;
            if_pc_o    <= pc;
            pc         <= pc + XLEN'(INSTR_BYTES);
         end else if (!stall_i) begin
            // Decode consumed the word this cycle
            if_valid_o <= 1'b0;
         end
      end
   end

`ifdef PC_FETCH_BRANCH_STATS_EN
   branch_stats u_branch_stats (
      .clk         (clk),
      .rst_n       (rst_n),
      .br_valid_i  (br_valid_i),
      .redirect_i  (redirect),
      .br_cnt_o    (br_cnt_o),
      .taken_cnt_o (taken_cnt_o)
   );
`else
   // Branch statistics not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Desc     : Self-checking bench for pc_fetch_ctrl: directed scenarios plus a
//            randomized run against an instruction-stream reference model.
// Config   : PC_FETCH_BRANCH_STATS_EN enables the counter checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        br_valid_i;
   logic        br_taken_i;
   logic [31:0] br_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        if_valid_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic        flush_o;
   logic        misalign_o;
`ifdef PC_FETCH_BRANCH_STATS_EN
   logic [31:0] br_cnt_o;
   logic [31:0] taken_cnt_o;
`endif

   int total;
   int bad;

   pc_fetch_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .br_valid_i    (br_valid_i),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_valid_o    (if_valid_o),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .flush_o       (flush_o),
      .misalign_o    (misalign_o)
`ifdef PC_FETCH_BRANCH_STATS_EN
      ,
      .br_cnt_o      (br_cnt_o),
      .taken_cnt_o   (taken_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a distinct word per address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic clear_in();
      stall_i       = 1'b0;
      br_valid_i    = 1'b0;
      br_taken_i    = 1'b0;
      br_target_i   = 32'h0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      repeat (3) nxt();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic branch(input logic taken, input logic [31:0] tgt);
      br_valid_i  = 1'b1;
      br_taken_i  = taken;
      br_target_i = tgt;
   endtask

   task automatic test_reset();
      clear_in();
      rst_n = 1'b0;
      nxt(); nxt(); #1;
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req_o); end
      total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", if_valid_o); end
      total++; if (if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin bad++; $display("FAIL rst_ifregs got=%h/%h want=0/0", if_pc_o, if_instr_o); end
      total++; if (flush_o !== 1'b0 || misalign_o !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b want=00", flush_o, misalign_o); end
`ifdef PC_FETCH_BRANCH_STATS_EN
      total++; if (br_cnt_o !== 32'h0 || taken_cnt_o !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", br_cnt_o, taken_cnt_o); end
`endif
      rst_n = 1'b1; #1;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_first_req got=%b@%h want=1@0", imem_req_o, imem_addr_o); end
      // Reset while a request is outstanding: its late response must be ignored
      imem_gnt_i = 1'b1;
      nxt();
      imem_gnt_i = 1'b0; rst_n = 1'b0;
      nxt(); #1;
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b want=0", imem_req_o); end
      rst_n = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0);
      nxt();
      imem_rvalid_i = 1'b0; #1;
      total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rst_stale_resp got=%b want=0", if_valid_o); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_after_stale got=%b@%h want=1@0", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp = 32'(i * 4);
         total++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp) begin bad++; $display("FAIL seq_req%0d got=%b@%h want=1@%h", i, imem_req_o, imem_addr_o, exp); end
         nxt();
         imem_gnt_i = 1'b1; #1;
         total++; if (imem_addr_o !== exp) begin bad++; $display("FAIL seq_addr_stable%0d got=%h want=%h", i, imem_addr_o, exp); end
         nxt();
         imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(exp);
         nxt();
         imem_rvalid_i = 1'b0; #1;
         total++; if (if_valid_o !== 1'b1 || if_pc_o !== exp || if_instr_o !== mem_word(exp)) begin bad++; $display("FAIL seq_resp%0d got=%b pc=%h instr=%h want=1 pc=%h", i, if_valid_o, if_pc_o, if_instr_o, exp); end
      end
   endtask

   task automatic test_redirect_coincident();
      do_reset();
      imem_gnt_i = 1'b1;
      nxt();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0);
      branch(1'b1, 32'h100);
      nxt();
      clear_in(); #1;
      total++; if (flush_o !== 1'b1 || if_valid_o !== 1'b0) begin bad++; $display("FAIL redir_coinc_flush got=flush%b valid%b want=flush1 valid0", flush_o, if_valid_o); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin bad++; $display("FAIL redir_coinc_req got=%b@%h want=1@100", imem_req_o, imem_addr_o); end
      nxt();
      total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL redir_coinc_pulse got=%b want=0", flush_o); end
   endtask

   task automatic test_redirect_drain();
      do_reset();
      imem_gnt_i = 1'b1;
      nxt();
      imem_gnt_i = 1'b0;
      branch(1'b1, 32'h200);
      nxt();
      clear_in(); #1;
      total++; if (flush_o !== 1'b1 || imem_req_o !== 1'b0) begin bad++; $display("FAIL drain_enter got=flush%b req%b want=flush1 req0", flush_o, imem_req_o); end
      nxt();
      nxt();
      imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0);
      nxt();
      imem_rvalid_i = 1'b0; #1;
      total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL drain_discard got=%b want=0", if_valid_o); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin bad++; $display("FAIL drain_req got=%b@%h want=1@200", imem_req_o, imem_addr_o); end
      imem_gnt_i = 1'b1;
      nxt();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h200);
      nxt();
      imem_rvalid_i = 1'b0; #1;
      total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h200 || if_instr_o !== mem_word(32'h200)) begin bad++; $display("FAIL drain_fetch got=%b pc=%h instr=%h want=1 pc=200", if_valid_o, if_pc_o, if_instr_o); end
   endtask

   task automatic test_misalign();
      do_reset();
      imem_gnt_i = 1'b1;
      nxt();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0);
      branch(1'b1, 32'h102);
      nxt();
      clear_in(); #1;
      total++; if (misalign_o !== 1'b1 || flush_o !== 1'b0) begin bad++; $display("FAIL mis_pulse got=mis%b flush%b want=mis1 flush0", misalign_o, flush_o); end
      total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) begin bad++; $display("FAIL mis_keep got=%b pc=%h want=1 pc=0", if_valid_o, if_pc_o); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin bad++; $display("FAIL mis_seq got=%b@%h want=1@4", imem_req_o, imem_addr_o); end
      nxt();
      total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_one_cycle got=%b want=0", misalign_o); end
      // Not-taken branch: no flush, no misalign, PC unchanged
      branch(1'b0, 32'h300);
      nxt();
      clear_in(); #1;
      total++; if (flush_o !== 1'b0 || misalign_o !== 1'b0 || imem_addr_o !== 32'h4) begin bad++; $display("FAIL not_taken got=flush%b mis%b addr=%h want=0 0 4", flush_o, misalign_o, imem_addr_o); end
   endtask

   task automatic test_stall();
      do_reset();
      imem_gnt_i = 1'b1;
      nxt();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0); stall_i = 1'b1;
      nxt();
      imem_rvalid_i = 1'b0; #1;
      for (int i = 0; i < 5; i++) begin
         total++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== mem_word(32'h0) || imem_req_o !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=v%b pc=%h instr=%h req=%b want=v1 pc=0 req0", i, if_valid_o, if_pc_o, if_instr_o, imem_req_o); end
         nxt();
      end
      branch(1'b1, 32'h300);
      nxt();
      br_valid_i = 1'b0; br_taken_i = 1'b0; #1;
      total++; if (flush_o !== 1'b1 || if_valid_o !== 1'b0) begin bad++; $display("FAIL stall_redir got=flush%b valid%b want=flush1 valid0", flush_o, if_valid_o); end
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin bad++; $display("FAIL stall_redir_req got=%b@%h want=1@300", imem_req_o, imem_addr_o); end
      clear_in();
   endtask

   task automatic test_wrap();
      do_reset();
      branch(1'b1, 32'hFFFF_FFFC);
      nxt();
      clear_in(); #1;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%b@%h want=1@fffffffc", imem_req_o, imem_addr_o); end
      imem_gnt_i = 1'b1;
      nxt();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'hFFFF_FFFC);
      nxt();
      imem_rvalid_i = 1'b0; #1;
      total++; if (if_pc_o !== 32'hFFFF_FFFC || imem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_next got=pc%h addr%h want=pc fffffffc addr 0", if_pc_o, imem_addr_o); end
   endtask

`ifdef PC_FETCH_BRANCH_STATS_EN
   task automatic test_stats();
      do_reset();
      branch(1'b1, 32'h40);
      nxt();
      branch(1'b0, 32'h60);
      nxt();
      branch(1'b1, 32'h80);
      nxt();
      clear_in(); #1;
      total++; if (br_cnt_o !== 32'd3 || taken_cnt_o !== 32'd2) begin bad++; $display("FAIL stats got=%0d/%0d want=3/2", br_cnt_o, taken_cnt_o); end
   endtask
`endif

   // Random stimulus checked against the architectural instruction stream:
   // every delivered word must be the next address of the program order,
   // which only a taken, aligned branch rewrites.
   task automatic test_random();
      logic [31:0] model_pc;
      logic [31:0] mem_addr;
      logic [31:0] last_addr;
      logic [31:0] prev_if_pc;
      logic [31:0] tgt;
      logic        mem_pend;
      logic        exp_flush;
      logic        exp_mis;
      logic        prev_valid;
      logic        prev_stall;
      logic        prev_redir;
      logic        last_req_wait;
      logic        redir;
      int          mem_lat;
      int          delivered;
      do_reset();
      model_pc = 32'h0; mem_addr = 32'h0; last_addr = 32'h0; prev_if_pc = 32'h0;
      mem_pend = 1'b0; exp_flush = 1'b0; exp_mis = 1'b0; prev_valid = 1'b0;
      prev_stall = 1'b0; prev_redir = 1'b0; last_req_wait = 1'b0;
      mem_lat = 0; delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         total++; if (flush_o !== exp_flush) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b want=%b", cyc, flush_o, exp_flush); end
         total++; if (misalign_o !== exp_mis) begin bad++; $display("FAIL rnd_misalign cyc=%0d got=%b want=%b", cyc, misalign_o, exp_mis); end
         if (prev_redir) begin
            total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_flush_valid cyc=%0d got=%b want=0", cyc, if_valid_o); end
         end else if (prev_valid && prev_stall) begin
            total++; if (if_valid_o !== 1'b1 || if_pc_o !== prev_if_pc) begin bad++; $display("FAIL rnd_hold cyc=%0d got=v%b pc=%h want=v1 pc=%h", cyc, if_valid_o, if_pc_o, prev_if_pc); end
         end else if (if_valid_o) begin
            delivered++;
            total++; if (if_pc_o !== model_pc || if_instr_o !== mem_word(model_pc)) begin bad++; $display("FAIL rnd_stream cyc=%0d got=pc%h instr%h want=pc%h instr%h", cyc, if_pc_o, if_instr_o, model_pc, mem_word(model_pc)); end
            model_pc = model_pc + 32'd4;
         end
         if (last_req_wait && !prev_redir) begin
            total++; if (imem_req_o !== 1'b1 || imem_addr_o !== last_addr) begin bad++; $display("FAIL rnd_addr_stable cyc=%0d got=%b@%h want=1@%h", cyc, imem_req_o, imem_addr_o, last_addr); end
         end
         prev_valid = if_valid_o;
         prev_if_pc = if_pc_o;

         stall_i    = ($urandom_range(0, 3) == 0);
         br_valid_i = ($urandom_range(0, 9) == 0);
         br_taken_i = 1'($urandom_range(0, 1));
         tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
         if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         br_target_i = tgt;
         redir     = br_valid_i && br_taken_i && (tgt[1:0] == 2'b00);
         exp_flush = redir;
         exp_mis   = br_valid_i && br_taken_i && (tgt[1:0] != 2'b00);

         imem_rvalid_i = 1'b0;
         if (mem_pend) begin
            if (mem_lat == 0) begin
               imem_rvalid_i = 1'b1;
               imem_rdata_i  = mem_word(mem_addr);
            end else begin
               mem_lat--;
            end
         end
         #1;
         total++; if (imem_req_o && (mem_pend || (if_valid_o && stall_i))) begin bad++; $display("FAIL rnd_req_legal cyc=%0d got=req1 pend%b hold%b want=req0", cyc, mem_pend, if_valid_o && stall_i); end
         if (imem_rvalid_i) mem_pend = 1'b0;
         imem_gnt_i = imem_req_o ? 1'($urandom_range(0, 1)) : 1'b0;
         if (imem_req_o && imem_gnt_i) begin
            mem_pend = 1'b1;
            mem_addr = imem_addr_o;
            mem_lat  = $urandom_range(0, 2);
         end
         last_req_wait = imem_req_o && !imem_gnt_i;
         last_addr     = imem_addr_o;
         prev_stall    = stall_i;
         prev_redir    = redir;
         if (redir) model_pc = tgt;
         nxt();
      end
      total++; if (delivered < 100) begin bad++; $display("FAIL rnd_progress got=%0d want>=100", delivered); end
      clear_in();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      clear_in();
      test_reset();
      test_sequential();
      test_redirect_coincident();
      test_redirect_drain();
      test_misalign();
      test_stall();
      test_wrap();
`ifdef PC_FETCH_BRANCH_STATS_EN
      test_stats();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 Parameter XLEN, default 32, PC/instruction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall_i  input  1  decode not ready; hold fetch output and PC.
REQ-006 br_valid_i  input  1  execute stage resolves a branch/jump this cycle.
REQ-007 br_taken_i  input  1  PCNextSrc from branch unit; qualified by br_valid_i.
REQ-008 br_target_i  input  XLEN  redirect target (PC+imm or rd1+imm).
REQ-009 imem_req_o  output  1  instruction memory request.
REQ-010 imem_addr_o  output  XLEN  request address; equals the internal PC.
REQ-011 imem_gnt_i  input  1  request accepted this cycle.
REQ-012 imem_rvalid_i / imem_rdata_i  input  1 / XLEN  response strobe and data.
REQ-013 if_valid_o / if_instr_o / if_pc_o  output  1 / XLEN / XLEN  fetched instruction to decode.
REQ-014 flush_o  output  1  one-cycle pulse that kills younger pipeline instructions.
REQ-015 misalign_o  output  1  one-cycle pulse: taken target with target[1:0] != 0.

Function
REQ-016 FSM states: REQ (request issued), WAIT (one request outstanding), DRAIN (discard stale response); at most one outstanding request.
REQ-017 REQ: imem_req_o=1 when not stall_i and if_valid_o=0 or stall_i=0; on imem_gnt_i go WAIT.
REQ-018 WAIT: on imem_rvalid_i register if_instr_o=imem_rdata_i, if_pc_o=PC, if_valid_o=1; PC <= PC+4; go REQ.
REQ-019 if_valid_o, if_instr_o, if_pc_o hold unchanged while stall_i=1; no new request is issued while a valid instruction is held and stall_i=1.
REQ-020 Redirect = br_valid_i & br_taken_i & (br_target_i[1:0]==0); highest priority, overrides stall_i.
REQ-021 On redirect in cycle N: PC <= br_target_i; flush_o=1 and if_valid_o=0 in cycle N+1; imem_req_o with imem_addr_o=br_target_i no earlier than N+1.
REQ-022 Redirect in REQ with imem_gnt_i in same cycle, or in WAIT without imem_rvalid_i: go DRAIN; the next imem_rvalid_i is discarded, then go REQ.
REQ-023 Redirect in WAIT coincident with imem_rvalid_i: response discarded, go REQ directly.
REQ-024 Misaligned taken target: no redirect, PC unchanged by branch, misalign_o=1 in cycle N+1 only.
REQ-025 br_valid_i=1 with br_taken_i=0: no effect.
REQ-026 PC+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 imem_addr_o is stable while imem_req_o=1 and imem_gnt_i=0.

Reset
REQ-028 rst_n=0 at a rising edge: PC=RESET_PC, state=REQ, if_valid_o=0, if_instr_o=0, if_pc_o=0, flush_o=0, misalign_o=0, counters=0.
REQ-029 imem_req_o=0 during reset; first request at RESET_PC in cycle after rst_n rises.
REQ-030 Reset mid-WAIT: outstanding response arriving after reset is ignored (state enters DRAIN-equivalent only if imem_rvalid_i pending is flagged by the memory; otherwise dropped because state=REQ ignores imem_rvalid_i).

Configuration
REQ-031 Macro PC_FETCH_BRANCH_STATS_EN defined: adds outputs br_cnt_o and taken_cnt_o (32 bits each), counting br_valid_i and redirects, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-032 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-033 Shared package holds fetch FSM state enum, XLEN default, RESET_PC default and instruction-size constant (4).
REQ-034 Counters in one sub-module, branch_stats, instantiated only under PC_FETCH_BRANCH_STATS_EN; FSM and PC register in the top module.

Verification
REQ-035 Reset release, gnt and rvalid each one cycle later -> requests at 0x0, 0x4, 0x8; if_pc_o follows, if_valid_o=1 per response.
REQ-036 Redirect to 0x100 while WAIT, rvalid same cycle -> flush_o pulse next cycle, response dropped, next imem_addr_o=0x100.
REQ-037 Redirect to 0x200 in WAIT, rvalid 3 cycles later -> that response discarded (DRAIN), next request 0x200, if_pc_o=0x200.
REQ-038 Taken branch target 0x102 -> misalign_o one-cycle pulse, no flush_o, sequential PC continues.
REQ-039 stall_i=1 for 5 cycles with valid instruction -> outputs held, no imem_req_o; redirect during stall still flushes.
REQ-040 PC at 0xFFFF_FFFC fetched -> next imem_addr_o=0x0; with PC_FETCH_BRANCH_STATS_EN, 3 branches/2 taken -> br_cnt_o=3, taken_cnt_o=2.
